// File: rtl/ram_1port_arbiter.sv
// Two-requester round-robin arbiter sharing one single-port RAM.
// Each granted command occupies the RAM bus for exactly one cycle (ISSUE),
// and read data is returned to the issuing requester one cycle later.
module ram_1port_arbiter #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  ram_enb_q, ram_enb_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  busy_q, busy_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_id_q, rd_id_d;
  logic                  winner;

  // Next-state logic: arbitrate in IDLE, retire the bus command and capture read data in ISSUE.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    ram_enb_d   = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    busy_d      = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    rd_pend_d   = rd_pend_q;
    rd_id_d     = rd_id_q;
    winner      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On contention the requester that was not served last wins.
          winner      = (req0 && req1) ? ~last_q : req1;
          ram_addr_d  = winner ? addr1  : addr0;
          ram_wdata_d = winner ? wdata1 : wdata0;
          ram_enb_d   = winner ? we1    : we0;
          rd_pend_d   = winner ? ~we1   : ~we0;
          rd_id_d     = winner;
          ack0_d      = ~winner;
          ack1_d      = winner;
          busy_d      = 1'b1;
          last_d      = winner;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // The RAM refreshed ram_rdata on the falling edge inside this cycle.
        if (rd_pend_q) begin
          if (rd_id_q) begin
            rvalid1_d = 1'b1;
            rdata1_d  = ram_rdata;
          end else begin
            rvalid0_d = 1'b1;
            rdata0_d  = ram_rdata;
          end
        end
        rd_pend_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; a pending read return is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      ram_enb_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      rd_pend_q   <= 1'b0;
      rd_id_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      ram_enb_q   <= ram_enb_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      rd_pend_q   <= rd_pend_d;
      rd_id_q     <= rd_id_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = busy_q;
  assign ram_enb   = ram_enb_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_1port_arbiter.sv
// Testbench for ram_1port_arbiter: a behavioural single-port RAM is attached,
// and every access is predicted from a reference memory plus a round-robin
// grant model.
module tb_ram_1port_arbiter;

  localparam int AW = 7;
  localparam int DW = 4;

  logic          clk;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, rvalid0, rvalid1, busy, ram_enb;
  logic [DW-1:0] rdata0, rdata1, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  logic [DW-1:0] ramMem [2**AW];
  logic [DW-1:0] refMem [2**AW];
  logic [DW-1:0] expRdata [2];
  int            lastGrant;
  int            errors;
  int            checks;

  ram_1port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .ram_enb(ram_enb), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: writes on the rising edge when enabled.
  always @(posedge clk) begin
    if (ram_enb) ramMem[ram_addr] <= ram_wdata;
  end

  // Behavioural RAM: reads on the falling edge when not writing.
  always @(negedge clk) begin
    if (!ram_enb) ram_rdata <= ramMem[ram_addr];
  end

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setReq(input int id, input logic v);
    if (id == 0) req0 = v;
    else         req1 = v;
  endtask

  task automatic applyStimulus(input int id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end
  endtask

  // Called in the cycle where requester id is being arbitrated; follows it
  // through its bus cycle and its return cycle.
  task automatic issueOne(input int id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] expData;
    stepCycle();
    checkOutput($sformatf("ack%0d_issue", id), id == 0 ? ack0 : ack1, 1);
    checkOutput($sformatf("ack%0d_other", 1 - id), id == 0 ? ack1 : ack0, 0);
    checkOutput("busy_issue", busy, 1);
    checkOutput("ram_enb_issue", ram_enb, we);
    checkOutput("ram_addr_issue", ram_addr, a);
    if (we) checkOutput("ram_wdata_issue", ram_wdata, d);
    expData = refMem[a];
    if (we) refMem[a] = d;
    lastGrant = id;
    stepCycle();
    setReq(id, 1'b0);
    checkOutput("ack_after", {ack1, ack0}, 0);
    checkOutput("busy_after", busy, 0);
    checkOutput("ram_enb_after", ram_enb, 0);
    if (!we) expRdata[id] = expData;
    checkOutput("rvalid_return", {rvalid1, rvalid0}, we ? 0 : (id == 0 ? 1 : 2));
    checkOutput("rdata0", rdata0, expRdata[0]);
    checkOutput("rdata1", rdata1, expRdata[1]);
  endtask

  // One round: requester 0 and/or 1 raise a request in the current cycle.
  task automatic transact(input bit r0, input bit r1,
                          input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int first;
    if (r0) applyStimulus(0, w0, a0, d0);
    if (r1) applyStimulus(1, w1, a1, d1);
    first = (r0 && r1) ? (lastGrant == 0 ? 1 : 0) : (r1 ? 1 : 0);
    if (first == 0) issueOne(0, w0, a0, d0);
    else            issueOne(1, w1, a1, d1);
    if (r0 && r1) begin
      if (first == 0) issueOne(1, w1, a1, d1);
      else            issueOne(0, w0, a0, d0);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_acks"}, {ack1, ack0}, 0);
    checkOutput({tag, "_rvalids"}, {rvalid1, rvalid0}, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_ram_enb"}, ram_enb, 0);
    checkOutput({tag, "_ram_addr"}, ram_addr, 0);
    checkOutput({tag, "_ram_wdata"}, ram_wdata, 0);
    checkOutput({tag, "_rdata0"}, rdata0, 0);
    checkOutput({tag, "_rdata1"}, rdata1, 0);
  endtask

  initial begin
    logic [DW-1:0] v0, v1;
    logic [AW-1:0] ra0, ra1;
    int mode;
    errors = 0; checks = 0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    rst = 1'b1;
    lastGrant = 1;
    expRdata[0] = 0; expRdata[1] = 0;

    // Reset
    stepCycle();
    stepCycle();
    checkResetOutputs("reset");
    rst = 1'b0;

    // Single write then read of 0x05
    transact(1, 0, 1'b1, 7'h05, 4'hA, 1'b0, 7'h00, 4'h0);
    transact(1, 0, 1'b0, 7'h05, 4'h0, 1'b0, 7'h00, 4'h0);
    checkOutput("readback_0x05", expRdata[0], 4'hA);

    // Fill every address, both requesters streaming
    for (int i = 0; i < 64; i++) begin
      v0 = 4'($urandom); v1 = 4'($urandom);
      transact(1, 1, 1'b1, 7'(2 * i), v0, 1'b1, 7'(2 * i + 1), v1);
    end

    // Simultaneous reads of 0x10 and 0x11
    transact(1, 1, 1'b0, 7'h10, 4'h0, 1'b0, 7'h11, 4'h0);

    // Stream 8 writes each, then read back all 16 addresses
    for (int i = 0; i < 8; i++) begin
      ra0 = 7'($urandom); ra1 = 7'($urandom);
      v0 = 4'($urandom); v1 = 4'($urandom);
      transact(1, 1, 1'b1, 7'h20 + 7'(i), v0, 1'b1, 7'h30 + 7'(i), v1);
    end
    for (int i = 0; i < 8; i++) begin
      transact(1, 1, 1'b0, 7'h30 + 7'(i), 4'h0, 1'b0, 7'h20 + 7'(i), 4'h0);
    end

    // req1 held through ISSUE then dropped: no second grant
    transact(0, 1, 1'b0, 7'h00, 4'h0, 1'b1, 7'h44, 4'h6);
    stepCycle();
    checkOutput("no_double_ack1", {ack1, ack0}, 0);
    checkOutput("no_double_busy", busy, 0);

    // Reset during ISSUE of a write: the write still lands
    v0 = 4'($urandom);
    applyStimulus(0, 1'b1, 7'h33, v0);
    stepCycle();
    checkOutput("rstwr_ack0", ack0, 1);
    checkOutput("rstwr_enb", ram_enb, 1);
    refMem[7'h33] = v0;
    rst = 1'b1; req0 = 1'b0;
    stepCycle();
    rst = 1'b0;
    checkResetOutputs("rstwr");
    expRdata[0] = 0; expRdata[1] = 0; lastGrant = 1;
    transact(0, 1, 1'b0, 7'h00, 4'h0, 1'b0, 7'h33, 4'h0);

    // Reset during ISSUE of a read of 0x7F: the return is dropped
    applyStimulus(0, 1'b0, 7'h7F, 4'h0);
    stepCycle();
    checkOutput("rstrd_ack0", ack0, 1);
    checkOutput("rstrd_addr", ram_addr, 7'h7F);
    rst = 1'b1; req0 = 1'b0;
    stepCycle();
    rst = 1'b0;
    checkResetOutputs("rstrd");
    expRdata[0] = 0; expRdata[1] = 0; lastGrant = 1;
    stepCycle();
    checkOutput("rstrd_no_rvalid", {rvalid1, rvalid0}, 0);
    transact(1, 1, 1'b0, 7'h10, 4'h0, 1'b0, 7'h11, 4'h0);

    // Boundary addresses
    transact(1, 1, 1'b1, 7'h00, 4'hF, 1'b1, 7'h7F, 4'h0);
    transact(1, 1, 1'b0, 7'h7F, 4'h0, 1'b0, 7'h00, 4'h0);
    checkOutput("boundary_0x7F", expRdata[0], 4'h0);
    checkOutput("boundary_0x00", expRdata[1], 4'hF);

    // Randomized mix of single and contending accesses
    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 2));
      transact(mode != 1, mode != 0,
               1'($urandom), 7'($urandom), 4'($urandom),
               1'($urandom), 7'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
